tsu_q_rgs_n: RTL and testbench

TSU_Q_RGS_N -- requirements
Module: tsu_q_rgs_n

---
 rtl/tsu_q_rgs_n.sv | 166 ++++++++++++++++
 tb/tb_tsu_q_rgs_n.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/tsu_q_rgs_n.sv
// Register front-end for NUM_CH timestamp queues; each channel pops its head entry into a shadow.
// Optional: define TSU_Q_AUTO_POP_EN so a bus read of the last DATA word requests the next pop.
module tsu_q_rgs_n #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned Q_WORDS = 4,
  parameter int unsigned RD_LAT  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_in,
  input  logic                         rd_in,
  input  logic [7:0]                   addr_in,
  input  logic [31:0]                  data_in,
  output logic [31:0]                  data_out,
  output logic [NUM_CH-1:0]            q_rst_out,
  output logic [NUM_CH-1:0]            q_rd_en_out,
  input  logic [NUM_CH-1:0]            q_empty_in,
  input  logic [8*NUM_CH-1:0]          q_stat_in,
  input  logic [32*Q_WORDS*NUM_CH-1:0] q_data_in,
  output logic                         irq_out
);
  localparam int unsigned EntryW = 32 * Q_WORDS;

  typedef enum logic [1:0] {StIdle, StPop, StWait, StCapt} state_e;

  logic [2:0]        a_ch, a_reg;
  logic [NUM_CH-1:0] busy, irq_en;
  logic [31:0]       ch_rdata [NUM_CH];
  logic [31:0]       rdata;
  logic              unused_bits;

  assign a_ch        = addr_in[7:5];
  assign a_reg       = addr_in[4:2];
  assign unused_bits = ^{addr_in[1:0], data_in[31:3]};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e            state_q;
    logic [2:0]        cnt_q;
    logic              ok_q, err_q, ovr_q, irq_en_q;
    logic              rd_req_q, rst_req_q, rd_en_q, q_rst_q;
    logic [EntryW-1:0] shadow_q;
    logic              sel, wr_ctrl, rd_stat, auto_pop;
    logic [31:0]       rdata_c;

    assign sel     = (a_ch == 3'(c));
    assign wr_ctrl = wr_in & sel & (a_reg == 3'd0);
    assign rd_stat = rd_in & sel & (a_reg == 3'd1);
`ifdef TSU_Q_AUTO_POP_EN
    assign auto_pop = rd_in & sel & (a_reg == 3'(3 + Q_WORDS)) & ok_q;
`else
    assign auto_pop = 1'b0;
`endif

    // Write-1 actions are registered first, then acted on by the FSM one edge later.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_req_q  <= 1'b0;
        rst_req_q <= 1'b0;
        irq_en_q  <= 1'b0;
      end else begin
        rd_req_q  <= (wr_ctrl & data_in[0]) | auto_pop;
        rst_req_q <= wr_ctrl & data_in[1];
        if (wr_ctrl) irq_en_q <= data_in[2];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q  <= StIdle;
        cnt_q    <= 3'd0;
        ok_q     <= 1'b0;
        err_q    <= 1'b0;
        ovr_q    <= 1'b0;
        rd_en_q  <= 1'b0;
        q_rst_q  <= 1'b0;
        shadow_q <= '0;
      end else begin
        rd_en_q <= 1'b0;
        q_rst_q <= 1'b0;
        if (rd_stat) begin
          err_q <= 1'b0;
          ovr_q <= 1'b0;
        end
        if (rst_req_q) begin
          // Queue reset overrides any pending or in-flight pop.
          state_q  <= StIdle;
          cnt_q    <= 3'd0;
          ok_q     <= 1'b0;
          shadow_q <= '0;
          q_rst_q  <= 1'b1;
        end else begin
          if (rd_req_q && state_q != StIdle) ovr_q <= 1'b1;
          case (state_q)
            StIdle: begin
              if (rd_req_q) begin
                ok_q <= 1'b0;
                if (q_empty_in[c]) begin
                  err_q <= 1'b1;
                end else begin
                  state_q <= StPop;
                  rd_en_q <= 1'b1;
                end
              end
            end
            StPop: begin
              if (RD_LAT > 1) begin
                state_q <= StWait;
                cnt_q   <= 3'(RD_LAT - 2);
              end else begin
                state_q <= StCapt;
              end
            end
            StWait: begin
              if (cnt_q == 3'd0) state_q <= StCapt;
              else cnt_q <= cnt_q - 3'd1;
            end
            StCapt: begin
              shadow_q <= q_data_in[c*EntryW +: EntryW];
              ok_q     <= 1'b1;
              state_q  <= StIdle;
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end

    always_comb begin
      rdata_c = '0;
      if (sel) begin
        if (a_reg == 3'd0) begin
          rdata_c = {29'd0, irq_en_q, busy[c], ok_q};
        end else if (a_reg == 3'd1) begin
          rdata_c = {22'd0, err_q, ovr_q, q_stat_in[c*8 +: 8]};
        end else begin
          // Word 0 is the most significant word of the entry.
          for (int w = 0; w < Q_WORDS; w++) begin
            if (a_reg == 3'(4 + w)) rdata_c = shadow_q[(Q_WORDS-1-w)*32 +: 32];
          end
        end
      end
    end

    assign busy[c]        = (state_q != StIdle);
    assign irq_en[c]      = irq_en_q;
    assign q_rd_en_out[c] = rd_en_q;
    assign q_rst_out[c]   = q_rst_q;
    assign ch_rdata[c]    = rdata_c;
  end

  always_comb begin
    rdata = '0;
    for (int c = 0; c < NUM_CH; c++) rdata = rdata | ch_rdata[c];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= 32'd0;
      irq_out  <= 1'b0;
    end else begin
      if (rd_in) data_out <= rdata;
      irq_out <= |(irq_en & ~q_empty_in & ~busy);
    end
  end

endmodule

// File: tb/tb_tsu_q_rgs_n.sv
// Directed bench for tsu_q_rgs_n (NUM_CH=2, Q_WORDS=4, RD_LAT=2); inputs driven and outputs
// sampled on the falling clock edge.
module tb_tsu_q_rgs_n;
  logic         clk = 1'b0;
  logic         rst;
  logic         wr_in, rd_in;
  logic [7:0]   addr_in;
  logic [31:0]  data_in;
  logic [31:0]  data_out;
  logic [1:0]   q_rst_out, q_rd_en_out, q_empty_in;
  logic [15:0]  q_stat_in;
  logic [255:0] q_data_in;
  logic         irq_out;

  int n_checks = 0;
  int n_fail   = 0;
  int pops0 = 0, pops1 = 0, qrsts0 = 0;
  int p0, p1, r0;
  logic [31:0] rd;

  tsu_q_rgs_n #(.NUM_CH(2), .Q_WORDS(4), .RD_LAT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_in       (wr_in),
    .rd_in       (rd_in),
    .addr_in     (addr_in),
    .data_in     (data_in),
    .data_out    (data_out),
    .q_rst_out   (q_rst_out),
    .q_rd_en_out (q_rd_en_out),
    .q_empty_in  (q_empty_in),
    .q_stat_in   (q_stat_in),
    .q_data_in   (q_data_in),
    .irq_out     (irq_out)
  );

  always #5 clk = ~clk;

  // Pulse counters for pop and queue-reset strobes.
  always @(negedge clk) begin
    pops0  <= pops0 + int'(q_rd_en_out[0]);
    pops1  <= pops1 + int'(q_rd_en_out[1]);
    qrsts0 <= qrsts0 + int'(q_rst_out[0]);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Tasks start at a falling edge and return at the next falling edge.
  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    wr_in = 1'b1; addr_in = a; data_in = d;
    @(negedge clk);
    wr_in = 1'b0; data_in = 32'd0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    rd_in = 1'b1; addr_in = a;
    @(negedge clk);
    rd_in = 1'b0;
    d = data_out;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; wr_in = 1'b0; rd_in = 1'b0; addr_in = 8'd0; data_in = 32'd0;
    q_empty_in = 2'b11;
    q_stat_in  = {8'h03, 8'h05};
    q_data_in  = {128'h11111111_22222222_33333333_44444444,
                  128'hAAAA0000_BBBB0001_CCCC0002_DDDD0003};
    #2 rst = 1'b0;
    #1;
    check_eq("rst_data_out", data_out, 32'd0);
    check_eq("rst_q_rst", {30'd0, q_rst_out}, 32'd0);
    check_eq("rst_q_rd_en", {30'd0, q_rd_en_out}, 32'd0);
    check_eq("rst_irq", {31'd0, irq_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus_rd(8'h00, rd);
    check_eq("rst_ctrl0", rd, 32'd0);

    // Pop on channel 1.
    q_empty_in = 2'b01;
    p1 = pops1;
    bus_wr(8'h20, 32'h1);
    check_eq("pop_rd_en_early", {30'd0, q_rd_en_out}, 32'd0);
    idle(1);
    check_eq("pop_rd_en", {30'd0, q_rd_en_out}, 32'h2);
    idle(1);
    check_eq("pop_rd_en_end", {30'd0, q_rd_en_out}, 32'd0);
    bus_rd(8'h20, rd); check_eq("pop_ctrl_e3", rd, 32'h2);
    bus_rd(8'h20, rd); check_eq("pop_ctrl_e4", rd, 32'h2);
    bus_rd(8'h20, rd); check_eq("pop_ctrl_e5", rd, 32'h1);
    bus_rd(8'h30, rd); check_eq("pop_w0", rd, 32'h11111111);
    bus_rd(8'h34, rd); check_eq("pop_w1", rd, 32'h22222222);
    bus_rd(8'h38, rd); check_eq("pop_w2", rd, 32'h33333333);
    bus_rd(8'h3C, rd); check_eq("pop_w3", rd, 32'h44444444);
    check_eq("pop_count1", pops1 - p1, 32'd1);

    // Pop request on empty channel 0.
    p0 = pops0;
    bus_wr(8'h00, 32'h1);
    idle(3);
    check_eq("empty_no_pop", pops0 - p0, 32'd0);
    bus_rd(8'h04, rd); check_eq("empty_stat1", rd, 32'h205);
    bus_rd(8'h04, rd); check_eq("empty_stat2", rd, 32'h005);
    bus_rd(8'h00, rd); check_eq("empty_ctrl", rd, 32'h0);

    // Back-to-back pop requests: second one is an overrun.
    q_empty_in = 2'b00;
    p0 = pops0;
    bus_wr(8'h00, 32'h1);
    bus_wr(8'h00, 32'h1);
    idle(6);
    check_eq("ovr_one_pop", pops0 - p0, 32'd1);
    bus_rd(8'h04, rd); check_eq("ovr_stat", rd, 32'h105);
    bus_rd(8'h00, rd); check_eq("ovr_ctrl", rd, 32'h1);
    bus_rd(8'h1C, rd); check_eq("ovr_w3", rd, 32'hDDDD0003);

    // Queue reset together with pop request.
    p0 = pops0; r0 = qrsts0;
    bus_wr(8'h00, 32'h3);
    check_eq("qrst_early", {30'd0, q_rst_out}, 32'd0);
    idle(1);
    check_eq("qrst_pulse", {30'd0, q_rst_out}, 32'h1);
    idle(1);
    check_eq("qrst_end", {30'd0, q_rst_out}, 32'd0);
    idle(4);
    check_eq("qrst_no_pop", pops0 - p0, 32'd0);
    check_eq("qrst_one", qrsts0 - r0, 32'd1);
    bus_rd(8'h00, rd); check_eq("qrst_ctrl", rd, 32'h0);
    bus_rd(8'h10, rd); check_eq("qrst_shadow", rd, 32'h0);

    // Interrupt follows IRQ_EN and queue emptiness.
    bus_wr(8'h00, 32'h4);
    idle(1);
    check_eq("irq_on", {31'd0, irq_out}, 32'h1);
    q_empty_in = 2'b01;
    idle(2);
    check_eq("irq_empty", {31'd0, irq_out}, 32'h0);
    q_empty_in = 2'b00;

    // Same-cycle write and read: read returns the pre-write value.
    wr_in = 1'b1; rd_in = 1'b1; addr_in = 8'h00; data_in = 32'h0;
    @(negedge clk);
    wr_in = 1'b0; rd_in = 1'b0;
    check_eq("rw_pre", data_out, 32'h4);
    bus_rd(8'h00, rd); check_eq("rw_post", rd, 32'h0);

    // Unmapped addresses.
    bus_rd(8'h08, rd); check_eq("unmapped_08", rd, 32'h0);
    bus_rd(8'h44, rd); check_eq("unmapped_44", rd, 32'h0);

    // Asynchronous reset while channel 1 is in WAIT.
    bus_rd(8'h30, rd);
    bus_wr(8'h20, 32'h5);
    idle(2);
    rst = 1'b0;
    #1;
    check_eq("arst_data_out", data_out, 32'd0);
    check_eq("arst_q_rd_en", {30'd0, q_rd_en_out}, 32'd0);
    check_eq("arst_q_rst", {30'd0, q_rst_out}, 32'd0);
    check_eq("arst_irq", {31'd0, irq_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus_rd(8'h20, rd); check_eq("arst_ctrl1", rd, 32'h0);
    bus_rd(8'h30, rd); check_eq("arst_shadow1", rd, 32'h0);

    // DATA read of last word with OK=1.
    bus_wr(8'h00, 32'h1);
    idle(6);
    bus_rd(8'h00, rd); check_eq("ap_ctrl_ok", rd, 32'h1);
    q_data_in[127:0] = 128'h01010101_02020202_03030303_04040404;
    p0 = pops0;
    bus_rd(8'h1C, rd); check_eq("ap_old_w3", rd, 32'hDDDD0003);
`ifdef TSU_Q_AUTO_POP_EN
    idle(1);
    bus_rd(8'h00, rd); check_eq("ap_ctrl_busy", rd, 32'h2);
    idle(6);
    check_eq("ap_one_pop", pops0 - p0, 32'd1);
    bus_rd(8'h00, rd); check_eq("ap_ctrl_done", rd, 32'h1);
    bus_rd(8'h1C, rd); check_eq("ap_new_w3", rd, 32'h04040404);
`else
    idle(6);
    check_eq("noap_no_pop", pops0 - p0, 32'd0);
    bus_rd(8'h00, rd); check_eq("noap_ctrl", rd, 32'h1);
    bus_rd(8'h1C, rd); check_eq("noap_w3", rd, 32'hDDDD0003);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
